// File: rtl/issue_unit_pkg.sv
// Shared issue/CDB definitions used by the reservation stations, the issue
// unit and the CDB slot table.
package issue_unit_pkg;

  localparam int ROB_TAG_LEN     = 6;
  localparam int XLEN            = 32;
  localparam int MAX_LAT_DEFAULT = 4;
  // Wide enough for up to 16 reservation stations.
  localparam int SRC_LEN         = 4;

  // One scheduled CDB broadcast: which FU produces it and which ROB tag it wakes.
  typedef struct packed {
    logic                   valid;
    logic [SRC_LEN-1:0]     src;
    logic [ROB_TAG_LEN-1:0] tag;
  } pend_entry_t;

endpackage

// File: rtl/cdb_slot_table.sv
// CDB slot table: pend[d] holds the broadcast scheduled d cycles from now.
// The table shifts by one entry every cycle, accepts the writes of the
// instructions issued this cycle, and reports per RS whether the slot its
// FU latency targets is still free.
module cdb_slot_table
  import issue_unit_pkg::*;
#(
  parameter int                  NUM_RS  = 4,
  parameter int                  MAX_LAT = MAX_LAT_DEFAULT,
  parameter logic [NUM_RS*3-1:0] FU_LAT  = {3'd4, 3'd2, 3'd1, 3'd1}
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [NUM_RS-1:0]             wr_en,
  input  logic [NUM_RS*ROB_TAG_LEN-1:0] wr_tag,
  output pend_entry_t                   head,
  output logic [NUM_RS-1:0]             slot_free
);

  pend_entry_t pend     [MAX_LAT];
  pend_entry_t pend_nxt [MAX_LAT];

  // A latency-L issue lands in pend[L-1] after the shift, which is today's
  // pend[L]; a full-latency issue always lands in the freshly cleared top entry.
  always_comb begin
    slot_free = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (int'(FU_LAT[i*3 +: 3]) >= MAX_LAT) begin
        slot_free[i] = 1'b1;
      end else begin
        slot_free[i] = !pend[int'(FU_LAT[i*3 +: 3])].valid;
      end
    end
  end

  // Shift toward the head, clear the top, then drop in this cycle's issues.
  always_comb begin
    for (int d = 0; d < MAX_LAT - 1; d++) begin
      pend_nxt[d] = pend[d+1];
    end
    pend_nxt[MAX_LAT-1] = '0;
    if (flush) begin
      for (int d = 0; d < MAX_LAT; d++) begin
        pend_nxt[d] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (wr_en[i]) begin
          pend_nxt[int'(FU_LAT[i*3 +: 3]) - 1].valid = 1'b1;
          pend_nxt[int'(FU_LAT[i*3 +: 3]) - 1].src   = SRC_LEN'(i);
          pend_nxt[int'(FU_LAT[i*3 +: 3]) - 1].tag   = wr_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
        end
      end
    end
  end

  // Table register; reset drops every scheduled broadcast.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < MAX_LAT; d++) begin
        pend[d] <= '0;
      end
    end else begin
      for (int d = 0; d < MAX_LAT; d++) begin
        pend[d] <= pend_nxt[d];
      end
    end
  end

  assign head = pend[0];

endmodule

// File: rtl/issue_unit.sv
// Issue unit: round-robin issue of reservation stations onto fixed-latency
// FUs, reserving a CDB slot at issue time so broadcasts never collide.
// Optional build macro ISSUE_PERF_CNT_EN adds grant and CDB-stall counters.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int                  NUM_RS  = 4,
  parameter int                  MAX_LAT = MAX_LAT_DEFAULT,
  parameter logic [NUM_RS*3-1:0] FU_LAT  = {3'd4, 3'd2, 3'd1, 3'd1},
  localparam int                 SW      = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_RS-1:0]             insn_ready,
  input  logic [NUM_RS*ROB_TAG_LEN-1:0] dst_tag,
  input  logic [NUM_RS*XLEN-1:0]        fu_result,
  input  logic                          flush,
  output logic [NUM_RS-1:0]             issue,
  output logic                          wakeup,
  output logic [ROB_TAG_LEN-1:0]        wakeup_tag,
  output logic [XLEN-1:0]               wakeup_value,
  output logic [SW-1:0]                 wakeup_src
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_cdb_stall_cnt
`endif
);

  logic [SW-1:0]     rr_ptr;
  logic [SW-1:0]     rr_nxt;
  logic              any_grant;
  logic [NUM_RS-1:0] grant;
  logic [NUM_RS-1:0] slot_free;
  pend_entry_t       head;

  cdb_slot_table #(
    .NUM_RS  (NUM_RS),
    .MAX_LAT (MAX_LAT),
    .FU_LAT  (FU_LAT)
  ) u_slot_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .wr_en     (grant),
    .wr_tag    (dst_tag),
    .head      (head),
    .slot_free (slot_free)
  );

  // Greedy round-robin grant; a latency may be granted only once per cycle
  // since equal latencies would target the same CDB slot. Reset gates the
  // grant so issue is low while reset is held.
  always_comb begin
    logic [7:0] lat_used;
    int         idx;
    int         lat;
    grant     = '0;
    any_grant = 1'b0;
    rr_nxt    = rr_ptr;
    lat_used  = '0;
    idx       = 0;
    lat       = 0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_RS;
      lat = int'(FU_LAT[idx*3 +: 3]);
      if (insn_ready[idx] && reset_n && !flush && slot_free[idx] && !lat_used[lat]) begin
        grant[idx]    = 1'b1;
        lat_used[lat] = 1'b1;
        if (!any_grant) begin
          any_grant = 1'b1;
          rr_nxt    = SW'((idx + 1) % NUM_RS);
        end
      end
    end
  end

  // Round-robin pointer follows the first granted RS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= rr_nxt;
    end
  end

  assign issue        = grant;
  assign wakeup       = head.valid & ~flush;
  assign wakeup_tag   = head.tag;
  assign wakeup_src   = head.src[SW-1:0];
  assign wakeup_value = wakeup ? fu_result[int'(head.src)*XLEN +: XLEN] : '0;

`ifdef ISSUE_PERF_CNT_EN
  logic stall;

  // Outside flush and reset, a ready RS left ungranted lost to a slot conflict.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (insn_ready[i] && reset_n && !flush && !grant[i]) begin
        stall = 1'b1;
      end
    end
  end

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt     <= '0;
      perf_cdb_stall_cnt <= '0;
    end else begin
      perf_issue_cnt     <= perf_issue_cnt + 32'($countones(grant));
      perf_cdb_stall_cnt <= perf_cdb_stall_cnt + {31'b0, stall};
    end
  end
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: per-cycle expected grants from scenario tables,
// expected CDB broadcasts held in a due-cycle ordered scoreboard queue.
module tb_issue_unit;
  import issue_unit_pkg::*;

  localparam int NUM_RS = 4;
  localparam int SW     = 2;

  typedef struct {
    int due;
    int src;
    int tag;
  } exp_t;

  logic                          clk;
  logic                          reset_n;
  logic [NUM_RS-1:0]             insn_ready;
  logic [NUM_RS*ROB_TAG_LEN-1:0] dst_tag;
  logic [NUM_RS*XLEN-1:0]        fu_result;
  logic                          flush;
  logic [NUM_RS-1:0]             issue;
  logic                          wakeup;
  logic [ROB_TAG_LEN-1:0]        wakeup_tag;
  logic [XLEN-1:0]               wakeup_value;
  logic [SW-1:0]                 wakeup_src;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]                   perf_issue_cnt;
  logic [31:0]                   perf_cdb_stall_cnt;
`endif

  int          lat_of [NUM_RS] = '{1, 1, 2, 4};
  logic [31:0] fu_val [NUM_RS];
  int          tagv   [NUM_RS];
  exp_t        sbq[$];
  int          cyc;
  int          total;
  int          bad;

  issue_unit u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .insn_ready   (insn_ready),
    .dst_tag      (dst_tag),
    .fu_result    (fu_result),
    .flush        (flush),
    .issue        (issue),
    .wakeup       (wakeup),
    .wakeup_tag   (wakeup_tag),
    .wakeup_value (wakeup_value),
    .wakeup_src   (wakeup_src)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issue_cnt     (perf_issue_cnt),
    .perf_cdb_stall_cnt (perf_cdb_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic set_ops(input int base);
    for (int i = 0; i < NUM_RS; i++) begin
      tagv[i]   = base + i;
      fu_val[i] = 32'hA000_0000 + 32'(base * 256 + i * 17);
      dst_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN] = ROB_TAG_LEN'(tagv[i]);
      fu_result[i*XLEN +: XLEN]             = fu_val[i];
    end
  endtask

  task automatic push_exp(input int due, input int src, input int tag);
    exp_t e;
    int   pos;
    e.due = due;
    e.src = src;
    e.tag = tag;
    pos   = sbq.size();
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due > due) pos = i;
    end
    sbq.insert(pos, e);
  endtask

  // One cycle: drive, compare mid-cycle, schedule expectations, advance.
  task automatic step(input logic [3:0] rdy, input logic [3:0] exp_iss, input logic fl);
    exp_t e;
    insn_ready = rdy;
    flush      = fl;
    @(negedge clk);
    chk("issue", 32'(issue), 32'(exp_iss));
    if (!fl && sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("wakeup", 32'(wakeup), 32'd1);
      chk("wk_tag", 32'(wakeup_tag), 32'(e.tag));
      chk("wk_src", 32'(wakeup_src), 32'(e.src));
      chk("wk_val", wakeup_value, fu_val[e.src]);
    end else begin
      chk("no_wakeup", 32'(wakeup), 32'd0);
      chk("wk_val_zero", wakeup_value, 32'd0);
    end
    if (fl) begin
      sbq.delete();
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (exp_iss[i]) push_exp(cyc + lat_of[i], i, tagv[i]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    insn_ready = '0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b0);
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release before cycle 0.
  task automatic do_reset(input logic [3:0] rdy);
    insn_ready = rdy;
    reset_n    = 1'b0;
    #1;
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_wakeup", 32'(wakeup), 32'd0);
    chk("rst_tag", 32'(wakeup_tag), 32'd0);
    chk("rst_src", 32'(wakeup_src), 32'd0);
    chk("rst_val", wakeup_value, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    insn_ready = '0;
    sbq.delete();
    cyc = 0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    reset_n    = 1'b0;
    flush      = 1'b0;
    insn_ready = '0;
    dst_tag    = '0;
    fu_result  = '0;
    set_ops(5);

    // Single issue, 1-cycle FU.
    do_reset(4'b1111);
    step(4'b0001, 4'b0001, 1'b0);
    idle(3);

    // Two same-latency RS compete: alternating grants, one broadcast per cycle.
    set_ops(20);
    do_reset(4'b0000);
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0011, 4'b0010, 1'b0);
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0011, 4'b0010, 1'b0);
    idle(2);

    // Latency collision: RS2 blocked in cycle 2 by RS3's slot.
    set_ops(8);
    do_reset(4'b0000);
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    idle(3);

    // Parallel issue of distinct latencies.
    set_ops(40);
    do_reset(4'b0000);
    step(4'b1101, 4'b1101, 1'b0);
    idle(4);

    // Flush squashes RS3's pending broadcast and blocks a ready RS0.
    set_ops(12);
    do_reset(4'b0000);
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b1);
    idle(3);

    // Reset mid-flight drops pending broadcasts; grant right after release.
    set_ops(30);
    do_reset(4'b0000);
    step(4'b1001, 4'b1001, 1'b0);
    chk("pre_rst_wakeup", 32'(wakeup), 32'd1);
    do_reset(4'b1001);
    step(4'b0001, 4'b0001, 1'b0);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 SHALL have parameter NUM_RS, default 4, giving the number of reservation stations scheduled.
REQ-002 SHALL have parameter MAX_LAT, default 4, giving the maximum FU latency in cycles.
REQ-003 SHALL have parameter FU_LAT, a packed NUM_RS x 3-bit vector, default {4,2,1,1} (RS3..RS0), giving the fixed FU latency per RS; each value is in 1..MAX_LAT.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port insn_ready, input, NUM_RS bits: per-RS "a ready instruction exists" flag.
REQ-007 SHALL have port dst_tag, input, NUM_RS x ROB_TAG_LEN bits: per-RS destination tag of the instruction it would issue.
REQ-008 SHALL have port fu_result, input, NUM_RS x XLEN bits: per-FU result value.
REQ-009 SHALL have port flush, input, 1 bit: squash all in-flight broadcasts.
REQ-010 SHALL have port issue, output, NUM_RS bits: per-RS issue grant.
REQ-011 SHALL have port wakeup, output, 1 bit: CDB broadcast valid.
REQ-012 SHALL have port wakeup_tag, output, ROB_TAG_LEN bits: broadcast tag.
REQ-013 SHALL have port wakeup_value, output, XLEN bits: broadcast value.
REQ-014 SHALL have port wakeup_src, output, clog2(NUM_RS) bits: index of the producing FU.

Function
REQ-015 Slot table SHALL hold entries pend[0..MAX_LAT-1] {valid, src, tag}; pend[d] is the broadcast d cycles from now.
REQ-016 Every edge SHALL shift pend[d] <= pend[d+1] and clear pend[MAX_LAT-1].
REQ-017 Slot check: RS i SHALL be slot-free when FU_LAT[i]==MAX_LAT or pend[FU_LAT[i]].valid==0.
REQ-018 issue SHALL be combinational from the current-cycle insn_ready plus registered state only: no dependency on fu_result, and no combinational loop to the wakeup outputs.
REQ-019 Grant SHALL be greedy in round-robin order starting at rr_ptr: grant RS i if insn_ready[i], slot-free, no earlier grant this cycle with equal FU_LAT, and flush==0.
REQ-020 Multiple RS MAY be granted in one cycle only if their FU_LAT values are pairwise distinct.
REQ-021 At the edge ending a cycle with issue[i]=1, pend[FU_LAT[i]-1] SHALL be written {1, i, dst_tag[i]}.
REQ-022 An instruction issued in cycle c SHALL broadcast in cycle c+FU_LAT[i]: wakeup=1, wakeup_tag=captured tag, wakeup_src=i.
REQ-023 wakeup, wakeup_tag and wakeup_src SHALL be driven directly from pend[0] registers.
REQ-024 wakeup_value SHALL be fu_result[pend[0].src], combinational, and 0 when wakeup=0.
REQ-025 rr_ptr SHALL advance to (first granted index in RR order)+1 mod NUM_RS, and hold when nothing is granted.
REQ-026 flush=1 SHALL force issue=0 and wakeup=0 that cycle, and clear every pend valid at the edge.
REQ-027 With every insn_ready low, state SHALL shift only; no spurious wakeup SHALL occur.

Reset
REQ-028 reset_n=0 SHALL immediately clear all pend entries and rr_ptr, giving issue=0, wakeup=0, wakeup_tag=0, wakeup_src=0, wakeup_value=0.
REQ-029 Reset mid-flight SHALL drop all pending broadcasts; the first grant SHALL be possible in the first cycle after release.

Configuration
REQ-030 With macro ISSUE_PERF_CNT_EN defined, 32-bit outputs perf_issue_cnt (total grants) and perf_cdb_stall_cnt (cycles with a ready RS left ungranted due to a slot conflict) SHALL exist, wrap on overflow, and reset to 0.
REQ-031 Without ISSUE_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-032 The PEND_ENTRY typedef, ROB_TAG_LEN, XLEN and the default MAX_LAT SHALL live in the shared header/package used by the reservation stations.
REQ-033 The slot table (shift, write, slot-free query) SHALL be sub-module cdb_slot_table; grant logic SHALL stay in issue_unit.

Verification
REQ-034 Single issue: insn_ready=0001, dst_tag[0]=5, cycle 0 -> issue=0001 in cycle 0; wakeup=1, tag=5 in cycle 1, with wakeup_value=fu_result[0].
REQ-035 Same-latency conflict: insn_ready=0011 held, rr_ptr=0 -> issue alternates 0001, 0010, 0001; exactly one wakeup per cycle from cycle 1.
REQ-036 Latency collision: RS3 (L=4) issued in cycle 0, RS2 (L=2) ready in cycle 2 -> RS2 blocked in cycle 2 (slot 4 taken), issued in cycle 3, broadcast in cycle 5; RS3 broadcasts in cycle 4.
REQ-037 Parallel issue: insn_ready=1101 in cycle 0 -> issue=1101; wakeups in cycles 1, 2 and 4 with srcs 0, 2 and 3.
REQ-038 Flush: RS3 issued in cycle 0, flush=1 in cycle 2 -> no wakeup in cycles 2-4.
REQ-039 Reset: reset_n asserted low in cycle 1 mid-flight -> all outputs 0 immediately; no wakeup after release.
